// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants for the forwarding / hazard controller.
package fwd_hazard_ctrl_pkg;

    localparam int REG_ADDR_WIDTH_DEF = 5;
    localparam int CNT_WIDTH_DEF      = 16;

    // Forwarding mux select codes, in mux_3x1 input order
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    // MEM is the younger producer, so it wins over WB
    function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage inputs, branch resolution and hazard/forwarding outputs of the controller.
interface fwd_hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
);
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      ex_branch_taken;
    logic [1:0]                fwd_a_sel;
    logic [1:0]                fwd_b_sel;
    logic                      stall;
    logic                      flush;
    logic [CNT_WIDTH-1:0]      load_use_cnt;
    logic [CNT_WIDTH-1:0]      flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, ex_branch_taken,
        input  fwd_a_sel, fwd_b_sel, stall, flush, load_use_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, ex_branch_taken,
        output fwd_a_sel, fwd_b_sel, stall, flush, load_use_cnt, flush_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    // Count up on enable, hold once all-ones is reached
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use stall and branch flush control for the EX stage,
// with the EX/MEM/WB bookkeeping records and debug event counters.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input logic              i_clk,
    input logic              i_rstn,
    fwd_hazard_ctrl_if.slave bus
);
    logic                      r_ex_valid;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rs1;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rs2;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rd;
    logic                      r_ex_reg_write;
    logic                      r_ex_mem_read;
    logic                      r_mem_valid;
    logic [REG_ADDR_WIDTH-1:0] r_mem_rd;
    logic                      r_mem_reg_write;
    logic                      r_wb_valid;
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
    logic                      r_wb_reg_write;

    logic                      w_mem_wr;
    logic                      w_wb_wr;
    logic [1:0]                w_fwd_a;
    logic [1:0]                w_fwd_b;
    logic                      w_load_use;
    logic                      w_flush;
    logic                      w_stall;
    logic [CNT_WIDTH-1:0]      w_load_use_cnt;
    logic [CNT_WIDTH-1:0]      w_flush_cnt;

    // Producer qualification (x0 never forwarded) and hazard detection
    always_comb begin
        w_mem_wr   = r_mem_valid & r_mem_reg_write & (r_mem_rd != '0);
        w_wb_wr    = r_wb_valid & r_wb_reg_write & (r_wb_rd != '0);
        w_fwd_a    = fwd_select(w_mem_wr & (r_mem_rd == r_ex_rs1), w_wb_wr & (r_wb_rd == r_ex_rs1));
        w_fwd_b    = fwd_select(w_mem_wr & (r_mem_rd == r_ex_rs2), w_wb_wr & (r_wb_rd == r_ex_rs2));
        w_load_use = r_ex_valid & r_ex_mem_read & (r_ex_rd != '0) & bus.id_valid &
                     ((r_ex_rd == bus.id_rs1) | (r_ex_rd == bus.id_rs2));
        w_flush    = r_ex_valid & bus.ex_branch_taken;
        // A flushed consumer is on the wrong path, so stalling for it is pointless
        w_stall    = w_load_use & ~w_flush;
    end

    // Advance the stage records; stall or flush inserts a bubble into EX
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_ex_valid      <= 1'b0;
            r_ex_rs1        <= '0;
            r_ex_rs2        <= '0;
            r_ex_rd         <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_mem_valid     <= 1'b0;
            r_mem_rd        <= '0;
            r_mem_reg_write <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_rd         <= '0;
            r_wb_reg_write  <= 1'b0;
        end else begin
            if (w_stall || w_flush) begin
                r_ex_valid     <= 1'b0;
                r_ex_rs1       <= '0;
                r_ex_rs2       <= '0;
                r_ex_rd        <= '0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
            end else begin
                r_ex_valid     <= bus.id_valid;
                r_ex_rs1       <= bus.id_rs1;
                r_ex_rs2       <= bus.id_rs2;
                r_ex_rd        <= bus.id_rd;
                r_ex_reg_write <= bus.id_reg_write;
                r_ex_mem_read  <= bus.id_mem_read;
            end
            r_mem_valid     <= r_ex_valid;
            r_mem_rd        <= r_ex_rd;
            r_mem_reg_write <= r_ex_reg_write;
            r_wb_valid      <= r_mem_valid;
            r_wb_rd         <= r_mem_rd;
            r_wb_reg_write  <= r_mem_reg_write;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_load_use_cnt (
        .i_clk   (i_clk),
        .i_clr_n (i_rstn),
        .i_inc   (w_stall),
        .o_count (w_load_use_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_clr_n (i_rstn),
        .i_inc   (w_flush),
        .o_count (w_flush_cnt)
    );

    // Outputs are held quiet while reset is asserted
    always_comb begin
        bus.fwd_a_sel    = i_rstn ? w_fwd_a : FWD_REGFILE;
        bus.fwd_b_sel    = i_rstn ? w_fwd_b : FWD_REGFILE;
        bus.stall        = i_rstn & w_stall;
        bus.flush        = i_rstn & w_flush;
        bus.load_use_cnt = i_rstn ? w_load_use_cnt : '0;
        bus.flush_cnt    = i_rstn ? w_flush_cnt : '0;
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding, load-use, flush, reset, saturation.
module tb_fwd_hazard_ctrl;
    logic clk = 1'b0;
    logic rstn;
    logic rstn2;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) bus ();
    fwd_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2))  bus2 ();

    fwd_hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    fwd_hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) dut2 (
        .i_clk  (clk),
        .i_rstn (rstn2),
        .bus    (bus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
    endtask

    task automatic set_id2(input logic v, input logic [4:0] rs1, input logic [4:0] rd,
                           input logic rw, input logic mr);
        bus2.id_valid     = v;
        bus2.id_rs1       = rs1;
        bus2.id_rs2       = 5'd0;
        bus2.id_rd        = rd;
        bus2.id_reg_write = rw;
        bus2.id_mem_read  = mr;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] a, input logic [1:0] b,
                            input logic st, input logic fl);
        chk({tag, ".fwd_a"}, {30'd0, bus.fwd_a_sel}, {30'd0, a});
        chk({tag, ".fwd_b"}, {30'd0, bus.fwd_b_sel}, {30'd0, b});
        chk({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, st});
        chk({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, fl});
    endtask

    initial begin
        rstn  = 1'b0;
        rstn2 = 1'b0;
        bus.ex_branch_taken  = 1'b0;
        bus2.ex_branch_taken = 1'b0;
        set_id2(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);

        // Reset held for two cycles with random ID traffic
        for (int i = 0; i < 2; i++) begin
            set_id(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(1, 31)), 1'b1, 1'b1);
            bus.ex_branch_taken = 1'b1;
            mid();
            chk_outs("rst", 2'b00, 2'b00, 1'b0, 1'b0);
            chk("rst.lu_cnt", 32'(bus.load_use_cnt), 32'd0);
            chk("rst.fl_cnt", 32'(bus.flush_cnt), 32'd0);
            next();
        end
        rstn = 1'b1;

        // First cycle after release: EX empty, taken branch cannot flush
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        bus.ex_branch_taken = 1'b1;
        mid();
        chk_outs("post_rst", 2'b00, 2'b00, 1'b0, 1'b0);
        chk("post_rst.lu_cnt", 32'(bus.load_use_cnt), 32'd0);
        chk("post_rst.fl_cnt", 32'(bus.flush_cnt), 32'd0);
        next();
        bus.ex_branch_taken = 1'b0;

        // add x5 ; add x6,x5,x5
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        next();
        set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
        mid();
        chk_outs("exmem.pre", 2'b00, 2'b00, 1'b0, 1'b0);
        next();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mid();
        chk_outs("exmem", 2'b10, 2'b10, 1'b0, 1'b0);
        next();

        // WB forward: add x7 ; add x10 ; add x11,x7,x3
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        next();
        set_id(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0);
        next();
        set_id(1'b1, 5'd7, 5'd3, 5'd11, 1'b1, 1'b0);
        next();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mid();
        chk_outs("wb", 2'b01, 2'b00, 1'b0, 1'b0);
        next();

        // Both MEM and WB write x7: MEM wins
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        next();
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        next();
        set_id(1'b1, 5'd7, 5'd7, 5'd12, 1'b1, 1'b0);
        next();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mid();
        chk_outs("prio", 2'b10, 2'b10, 1'b0, 1'b0);
        next();

        // x0 writer then x0 reader: no forward
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        next();
        set_id(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
        next();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mid();
        chk_outs("x0", 2'b00, 2'b00, 1'b0, 1'b0);
        chk("x0.lu_cnt", 32'(bus.load_use_cnt), 32'd0);
        next();

        // lw x8 ; add x9,x8,x1
        set_id(1'b1, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1);
        next();
        set_id(1'b1, 5'd8, 5'd1, 5'd9, 1'b1, 1'b0);
        mid();
        chk("lu.stall", {31'd0, bus.stall}, 32'd1);
        chk("lu.flush", {31'd0, bus.flush}, 32'd0);
        chk("lu.cnt_before", 32'(bus.load_use_cnt), 32'd0);
        next();
        mid();
        chk("lu.stall_one_cycle", {31'd0, bus.stall}, 32'd0);
        chk("lu.ex_bubble", {31'd0, dut.r_ex_valid}, 32'd0);
        chk("lu.cnt", 32'(bus.load_use_cnt), 32'd1);
        next();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mid();
        chk_outs("lu.wb", 2'b01, 2'b00, 1'b0, 1'b0);
        chk("lu.cnt_hold", 32'(bus.load_use_cnt), 32'd1);
        next();

        // Taken branch in EX while ID holds a load-use consumer
        set_id(1'b1, 5'd3, 5'd0, 5'd14, 1'b1, 1'b1);
        next();
        set_id(1'b1, 5'd14, 5'd14, 5'd15, 1'b1, 1'b0);
        bus.ex_branch_taken = 1'b1;
        mid();
        chk("br.flush", {31'd0, bus.flush}, 32'd1);
        chk("br.stall", {31'd0, bus.stall}, 32'd0);
        chk("br.fl_cnt_before", 32'(bus.flush_cnt), 32'd0);
        next();
        // EX now a bubble: taken signal alone must not flush
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mid();
        chk("br.ex_bubble", {31'd0, dut.r_ex_valid}, 32'd0);
        chk("br.no_flush_invalid", {31'd0, bus.flush}, 32'd0);
        chk("br.fl_cnt", 32'(bus.flush_cnt), 32'd1);
        chk("br.lu_cnt", 32'(bus.load_use_cnt), 32'd1);
        next();
        bus.ex_branch_taken = 1'b0;
        mid();
        chk("br.fl_cnt_hold", 32'(bus.flush_cnt), 32'd1);
        next();

        // Reset mid-operation discards in-flight add x16
        set_id(1'b1, 5'd1, 5'd2, 5'd16, 1'b1, 1'b0);
        next();
        set_id(1'b1, 5'd16, 5'd16, 5'd17, 1'b1, 1'b0);
        rstn = 1'b0;
        mid();
        chk_outs("mid_rst", 2'b00, 2'b00, 1'b0, 1'b0);
        next();
        rstn = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mid();
        chk_outs("mid_rst.after", 2'b00, 2'b00, 1'b0, 1'b0);
        chk("mid_rst.lu_cnt", 32'(bus.load_use_cnt), 32'd0);
        chk("mid_rst.fl_cnt", 32'(bus.flush_cnt), 32'd0);
        next();

        // Saturation on the 2-bit counter build: five load-use events
        rstn2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_id2(1'b1, 5'd2, 5'd8, 1'b1, 1'b1);
            mid();
            chk($sformatf("sat.cnt%0d", k), 32'(bus2.load_use_cnt), (k < 3) ? k : 3);
            next();
            set_id2(1'b1, 5'd8, 5'd9, 1'b1, 1'b0);
            mid();
            chk($sformatf("sat.stall%0d", k), {31'd0, bus2.stall}, 32'd1);
            next();
        end
        set_id2(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        mid();
        chk("sat.final", 32'(bus2.load_use_cnt), 32'd3);
        next();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
